uart_mmio_bridge: RTL and testbench

//  Memory-mapped front end between the pipeline's data-memory bus and the UART core.

---
 rtl/uart_mmio_pkg.sv | 29 ++
 rtl/sync_fifo.sv | 46 ++++
 rtl/uart_mmio_bridge.sv | 170 +++++++++++++++++
 tb/tb_uart_mmio_bridge.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_mmio_pkg.sv
// Shared definitions for the UART MMIO bridge: register map, STATUS layout, TX FSM states.
package uart_mmio_pkg;

    // Register select, taken from bus_addr[3:2]
    localparam logic [1:0] REG_TXDATA = 2'd0;
    localparam logic [1:0] REG_RXDATA = 2'd1;
    localparam logic [1:0] REG_STATUS = 2'd2;
    localparam logic [1:0] REG_RSVD   = 2'd3;

    // STATUS bit positions
    localparam int ST_TX_FULL    = 0;
    localparam int ST_TX_EMPTY   = 1;
    localparam int ST_RX_NONEMPTY = 2;
    localparam int ST_RX_FULL    = 3;
    localparam int ST_TX_OVF     = 4;
    localparam int ST_RX_OVR     = 5;

    // WAIT_BUSY timeout: the down-counter is loaded with this value on ISSUE and
    // the FSM gives up when it reaches zero, i.e. three cycles without busy.
    localparam logic [1:0] WAIT_BUSY_TC = 2'd2;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } tx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with extra-MSB pointers. Head is combinational from memory.
// A push on a full FIFO is accepted only if a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr[AW-1:0]];

    // Pointer update; pointers wrap naturally through the extra MSB
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage write, no reset needed
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/uart_mmio_bridge.sv
// Memory-mapped bridge between the data-memory bus and the UART core.
// TX bytes are queued and paced into the UART one at a time; RX bytes are
// captured on the rising edge of outValid and queued for the CPU to poll.
//
// TX FSM states
//   state     | meaning
//   IDLE      | waiting for queued data, UART not busy and ready
//   ISSUE     | uart_we high for one cycle with FIFO head on uart_data
//   WAIT_BUSY | waiting for UART to accept (busy); no busy in 3 cycles -> retry
//   WAIT_DONE | byte accepted and popped; waiting for busy to drop
module uart_mmio_bridge
    import uart_mmio_pkg::*;
#(
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  bus_addr,
    input  logic        bus_we,
    input  logic        bus_re,
    input  logic [31:0] bus_wdata,
    output logic [31:0] bus_rdata,
    output logic        bus_rvalid,
    output logic        uart_we,
    output logic [7:0]  uart_data,
    input  logic        uart_busy,
    input  logic        uart_ready,
    input  logic [7:0]  uart_rx_data,
    input  logic        uart_rx_vld,
    output logic        irq
);
    tx_state_e   state, state_nxt;
    logic [1:0]  wcnt, wcnt_nxt;
    logic [1:0]  reg_sel;
    logic        tx_wr, tx_push, tx_pop, tx_full, tx_empty;
    logic [7:0]  tx_head;
    logic        rx_rd, rx_pop, rx_push, rx_rise, rx_full, rx_empty;
    logic [7:0]  rx_head;
    logic        rx_vld_q;
    logic        sts_wr;
    logic        tx_ovf, rx_ovr;
    logic [5:0]  status;
    logic [31:0] rd_mux;
    logic        unused_bits;

    assign unused_bits = ^{bus_addr[1:0], bus_wdata[31:8]};

    assign reg_sel = bus_addr[3:2];
    assign tx_wr   = bus_we && (reg_sel == REG_TXDATA);
    assign tx_push = tx_wr && !tx_full;
    assign sts_wr  = bus_we && (reg_sel == REG_STATUS);
    assign rx_rd   = bus_re && (reg_sel == REG_RXDATA);
    assign rx_pop  = rx_rd && !rx_empty;
    assign rx_rise = uart_rx_vld && !rx_vld_q;
    // A rise into a full RX FIFO is still stored when the CPU pops in the same cycle
    assign rx_push = rx_rise && (!rx_full || rx_pop);

    assign uart_data = tx_empty ? 8'h00 : tx_head;

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (tx_push),
        .pop   (tx_pop),
        .din   (bus_wdata[7:0]),
        .full  (tx_full),
        .empty (tx_empty),
        .head  (tx_head)
    );

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rx_push),
        .pop   (rx_pop),
        .din   (uart_rx_data),
        .full  (rx_full),
        .empty (rx_empty),
        .head  (rx_head)
    );

    // TX FSM state and retry timer registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            wcnt  <= '0;
        end else begin
            state <= state_nxt;
            wcnt  <= wcnt_nxt;
        end
    end

    // TX FSM next-state, pop and write-enable decode
    always_comb begin
        state_nxt = state;
        wcnt_nxt  = wcnt;
        tx_pop    = 1'b0;
        uart_we   = 1'b0;
        case (state)
            IDLE: begin
                if (!tx_empty && !uart_busy && uart_ready) state_nxt = ISSUE;
            end
            ISSUE: begin
                uart_we   = 1'b1;
                wcnt_nxt  = WAIT_BUSY_TC;
                state_nxt = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (uart_busy) begin
                    tx_pop    = 1'b1;
                    state_nxt = WAIT_DONE;
                end else if (wcnt == 2'd0) begin
                    state_nxt = IDLE;
                end else begin
                    wcnt_nxt = wcnt - 2'd1;
                end
            end
            WAIT_DONE: begin
                if (!uart_busy) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Sticky overflow bits: set by dropped bytes, cleared by writing 1 to STATUS
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_ovf <= 1'b0;
            rx_ovr <= 1'b0;
        end else begin
            if (sts_wr && bus_wdata[ST_TX_OVF])  tx_ovf <= 1'b0;
            if (tx_wr && tx_full)                tx_ovf <= 1'b1;
            if (sts_wr && bus_wdata[ST_RX_OVR])  rx_ovr <= 1'b0;
            if (rx_rise && rx_full && !rx_pop)   rx_ovr <= 1'b1;
        end
    end

    // STATUS assembly and read-data mux
    always_comb begin
        status                 = '0;
        status[ST_TX_FULL]     = tx_full;
        status[ST_TX_EMPTY]    = tx_empty;
        status[ST_RX_NONEMPTY] = !rx_empty;
        status[ST_RX_FULL]     = rx_full;
        status[ST_TX_OVF]      = tx_ovf;
        status[ST_RX_OVR]      = rx_ovr;
        rd_mux = '0;
        case (reg_sel)
            REG_RXDATA: if (!rx_empty) rd_mux = {23'd0, 1'b1, rx_head};
            REG_STATUS: rd_mux = {26'd0, status};
            default:    rd_mux = '0;
        endcase
    end

    // Registered read response, RX edge detect and interrupt
    always_ff @(posedge clk) begin
        if (rst) begin
            bus_rvalid <= 1'b0;
            bus_rdata  <= '0;
            rx_vld_q   <= 1'b0;
            irq        <= 1'b0;
        end else begin
            bus_rvalid <= bus_re;
            if (bus_re) bus_rdata <= rd_mux;
            rx_vld_q   <= uart_rx_vld;
            irq        <= !rx_empty || tx_ovf || rx_ovr;
        end
    end

endmodule

// File: tb/tb_uart_mmio_bridge.sv
// Directed bench for uart_mmio_bridge: register-map vector table plus
// hand-written TX pacing, overflow, RX capture and reset sequences.
module tb_uart_mmio_bridge;

    logic        clk;
    logic        rst;
    logic [3:0]  bus_addr;
    logic        bus_we;
    logic        bus_re;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_rvalid;
    logic        uart_we;
    logic [7:0]  uart_data;
    logic        uart_busy;
    logic        uart_ready;
    logic [7:0]  uart_rx_data;
    logic        uart_rx_vld;
    logic        irq;

    int n_tests = 0;
    int n_fail  = 0;

    // UART model controls and transmit log
    logic       force_busy  = 1'b0;
    logic       never_busy  = 1'b0;
    int         busy_cnt    = 0;
    int         we_count    = 0;
    logic [7:0] we_data [64];
    int         we_cyc  [64];
    int         cyc     = 0;

    uart_mmio_bridge #(.FIFO_DEPTH(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus_addr     (bus_addr),
        .bus_we       (bus_we),
        .bus_re       (bus_re),
        .bus_wdata    (bus_wdata),
        .bus_rdata    (bus_rdata),
        .bus_rvalid   (bus_rvalid),
        .uart_we      (uart_we),
        .uart_data    (uart_data),
        .uart_busy    (uart_busy),
        .uart_ready   (uart_ready),
        .uart_rx_data (uart_rx_data),
        .uart_rx_vld  (uart_rx_vld),
        .irq          (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // UART core model: busy for 20 clk after each write_enable; logs every pulse
    always @(negedge clk) begin
        if (uart_we === 1'b1) begin
            if (we_count < 64) begin
                we_data[we_count] = uart_data;
                we_cyc[we_count]  = cyc;
            end
            we_count = we_count + 1;
            if (!never_busy) busy_cnt = 20;
        end else if (busy_cnt > 0) begin
            busy_cnt = busy_cnt - 1;
        end
        uart_busy = force_busy || (busy_cnt > 0);
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_write(input logic [3:0] addr, input logic [31:0] data);
        @(negedge clk);
        bus_addr  = addr;
        bus_wdata = data;
        bus_we    = 1'b1;
        @(negedge clk);
        bus_we    = 1'b0;
    endtask

    task automatic read_check(input string name, input logic [3:0] addr, input logic [31:0] exp);
        @(negedge clk);
        bus_addr = addr;
        bus_re   = 1'b1;
        @(negedge clk);
        bus_re   = 1'b0;
        check({name, "_rvalid"}, {31'd0, bus_rvalid}, 32'd1);
        check(name, bus_rdata, exp);
    endtask

    task automatic wait_we(input int target, input int budget, input string name);
        int n;
        n = 0;
        while (we_count < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, {31'd0, (we_count >= target)}, 32'd1);
    endtask

    task automatic rx_rise(input logic [7:0] d);
        @(negedge clk);
        uart_rx_data = d;
        uart_rx_vld  = 1'b1;
        wait_clk(2);
        uart_rx_vld  = 1'b0;
        wait_clk(2);
    endtask

    typedef struct {
        logic        we;
        logic [3:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [8];

    initial begin
        int base;
        logic all_ok;

        rst          = 1'b1;
        bus_addr     = '0;
        bus_we       = 1'b0;
        bus_re       = 1'b0;
        bus_wdata    = '0;
        uart_ready   = 1'b0;
        uart_rx_data = '0;
        uart_rx_vld  = 1'b0;
        uart_busy    = 1'b0;
        wait_clk(3);
        rst = 1'b0;
        wait_clk(1);

        check("reset_uart_we", {31'd0, uart_we}, 32'd0);
        check("reset_uart_data", {24'd0, uart_data}, 32'd0);
        check("reset_rvalid", {31'd0, bus_rvalid}, 32'd0);
        check("reset_rdata", bus_rdata, 32'd0);
        check("reset_irq", {31'd0, irq}, 32'd0);

        // Register map after reset: STATUS=tx_empty, empty RXDATA, reserved reg inert
        vecs[0] = '{1'b0, 4'h8, 32'h0,          32'h0000_0002};
        vecs[1] = '{1'b0, 4'h4, 32'h0,          32'h0000_0000};
        vecs[2] = '{1'b0, 4'hC, 32'h0,          32'h0000_0000};
        vecs[3] = '{1'b1, 4'hC, 32'hFFFF_FFFF,  32'h0};
        vecs[4] = '{1'b0, 4'hC, 32'h0,          32'h0000_0000};
        vecs[5] = '{1'b0, 4'h8, 32'h0,          32'h0000_0002};
        vecs[6] = '{1'b1, 4'h8, 32'h0000_0030,  32'h0};
        vecs[7] = '{1'b0, 4'h8, 32'h0,          32'h0000_0002};
        for (int i = 0; i < 8; i++) begin
            if (vecs[i].we) bus_write(vecs[i].addr, vecs[i].wdata);
            else read_check($sformatf("vec%0d", i), vecs[i].addr, vecs[i].exp);
        end

        // 1: two bytes paced into the UART in order
        uart_ready = 1'b1;
        base = we_count;
        bus_write(4'h0, 32'h0000_0041);
        bus_write(4'h0, 32'h0000_0042);
        wait_we(base + 2, 200, "t1_two_pulses");
        check("t1_byte0", {24'd0, we_data[base]}, 32'h41);
        check("t1_byte1", {24'd0, we_data[base+1]}, 32'h42);
        check("t1_gap_ge4", {31'd0, (we_cyc[base+1] - we_cyc[base] >= 4)}, 32'd1);
        wait_clk(40);
        check("t1_no_extra", we_count - base, 2);
        read_check("t1_status_empty", 4'h8, 32'h0000_0002);

        // 2: overflow of TX FIFO while UART is busy, then drain
        force_busy = 1'b1;
        wait_clk(2);
        base = we_count;
        for (int i = 0; i < 9; i++) bus_write(4'h0, 32'h10 + i);
        read_check("t2_status_full_ovf", 4'h8, 32'h0000_0011);
        wait_clk(1);
        check("t2_irq_ovf", {31'd0, irq}, 32'd1);
        bus_write(4'h8, 32'h0000_0010);
        read_check("t2_status_cleared", 4'h8, 32'h0000_0001);
        check("t2_held_no_we", we_count - base, 0);
        force_busy = 1'b0;
        wait_we(base + 8, 400, "t2_drain");
        all_ok = 1'b1;
        for (int i = 0; i < 8; i++)
            if (we_data[base+i] !== 8'(8'h10 + i)) all_ok = 1'b0;
        check("t2_drain_order", {31'd0, all_ok}, 32'd1);
        wait_clk(40);
        check("t2_dropped_byte", we_count - base, 8);
        check("t2_irq_clear", {31'd0, irq}, 32'd0);

        // 3: long outValid level stores exactly one byte
        @(negedge clk);
        uart_rx_data = 8'h5A;
        uart_rx_vld  = 1'b1;
        wait_clk(50);
        uart_rx_vld  = 1'b0;
        wait_clk(1);
        check("t3_irq_rx", {31'd0, irq}, 32'd1);
        read_check("t3_rx_byte", 4'h4, 32'h0000_015A);
        @(negedge clk);
        check("t3_rvalid_drop", {31'd0, bus_rvalid}, 32'd0);
        check("t3_rdata_hold", bus_rdata, 32'h0000_015A);
        read_check("t3_rx_empty", 4'h4, 32'h0000_0000);
        wait_clk(1);
        check("t3_irq_gone", {31'd0, irq}, 32'd0);

        // 3b: read of empty FIFO coinciding with a rise returns 0 and keeps the byte
        @(negedge clk);
        bus_addr     = 4'h4;
        bus_re       = 1'b1;
        uart_rx_data = 8'h3C;
        uart_rx_vld  = 1'b1;
        @(negedge clk);
        bus_re       = 1'b0;
        check("t3b_read_zero", bus_rdata, 32'h0);
        uart_rx_vld  = 1'b0;
        read_check("t3b_stored", 4'h4, 32'h0000_013C);

        // 4: RX overrun, then read+rise on a full FIFO, then drain in order
        for (int i = 0; i < 9; i++) rx_rise(8'hA0 + 8'(i));
        read_check("t4_status_full_ovr", 4'h8, 32'h0000_002E);
        bus_write(4'h8, 32'h0000_0020);
        read_check("t4_ovr_cleared", 4'h8, 32'h0000_000E);
        @(negedge clk);
        bus_addr     = 4'h4;
        bus_re       = 1'b1;
        uart_rx_data = 8'hEE;
        uart_rx_vld  = 1'b1;
        @(negedge clk);
        bus_re       = 1'b0;
        check("t4_full_pop_data", bus_rdata, 32'h0000_01A0);
        uart_rx_vld  = 1'b0;
        read_check("t4_full_no_ovr", 4'h8, 32'h0000_000E);
        for (int i = 1; i < 8; i++)
            read_check($sformatf("t4_rx%0d", i), 4'h4, 32'h100 + 32'hA0 + i);
        read_check("t4_rx_last", 4'h4, 32'h0000_01EE);
        read_check("t4_rx_after", 4'h4, 32'h0000_0000);

        // 5: uart_ready low blocks; a UART that never goes busy causes retries without pop
        uart_ready = 1'b0;
        base = we_count;
        bus_write(4'h0, 32'h0000_0077);
        wait_clk(30);
        check("t5_not_ready", we_count - base, 0);
        never_busy = 1'b1;
        uart_ready = 1'b1;
        wait_clk(40);
        check("t5_retries", {31'd0, (we_count - base >= 3)}, 32'd1);
        all_ok = 1'b1;
        for (int i = base; i < we_count && i < 64; i++)
            if (we_data[i] !== 8'h77) all_ok = 1'b0;
        check("t5_retry_data", {31'd0, all_ok}, 32'd1);
        read_check("t5_not_popped", 4'h8, 32'h0000_0000);

        // 6: reset while in WAIT_DONE
        rx_rise(8'h99);
        never_busy = 1'b0;
        base = we_count;
        wait_we(base + 1, 20, "t6_issue");
        wait_clk(3);
        check("t6_irq_before", {31'd0, irq}, 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t6_we_low", {31'd0, uart_we}, 32'd0);
        check("t6_irq_low", {31'd0, irq}, 32'd0);
        read_check("t6_status", 4'h8, 32'h0000_0002);
        base = we_count;
        wait_clk(40);
        check("t6_no_tx_after_rst", we_count - base, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
